// File: rtl/uart_mmio_bridge.sv
// Generic first-word-fall-through queue with read/write pointers and an occupancy count.
// Latency: a written entry reaches the head the cycle after its write edge; empty/full are 0-cycle from the count.
// Backpressure: a push while full and a pop while empty are ignored; callers gate on full_o/empty_o.
module uart_mmio_bridge_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   // Status is derived purely from the count so it is valid even while reset is asserted.
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign wr_en   = push_i && !full_o;
   assign rd_en   = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and count next-state; power-of-two depth makes pointer wrap implicit.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Bookkeeping registers; clearing them discards whatever is left in storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because the count masks stale entries.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// EX-stage MMIO bridge: RX bytes buffered for loads of 0x80000004, stores to 0x80000008 queued for TX.
// Latency: status and read data are combinational from FIFO state; pops/pushes land at the EX-cycle edge.
// Backpressure: RX ready drops when the RX FIFO is full; a store to a full TX FIFO is dropped and flagged.
module uart_mmio_bridge #(
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr_i,
   input  logic        mem_re_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [7:0]  uart_rx_data_out,
   input  logic        uart_rx_data_out_valid,
   output logic        uart_rx_data_out_ready,
   output logic [7:0]  uart_tx_data_in,
   output logic        uart_tx_data_in_valid,
   input  logic        uart_tx_data_in_ready,
   output logic        uart_rx_out_valid,
   output logic        uart_tx_in_ready,
   output logic [7:0]  uart_read_o,
   output logic        tx_overflow_o
);

   localparam logic [31:0] ADDR_RX_DATA = 32'h8000_0004;
   localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;

   logic       rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0] rx_head;
   logic       tx_push, tx_pop, tx_empty, tx_full;
   logic [7:0] tx_head;
   logic       ld_rx_hit, st_tx_hit;
   logic       tx_overflow_q, tx_overflow_d;
   logic       unused_wdata_hi;

   // Only the low byte of store data reaches the transmitter.
   assign unused_wdata_hi = ^mem_wdata_i[31:8];

   // Address decode and FIFO handshakes; loads and stores are evaluated independently.
   always_comb begin
      ld_rx_hit = mem_re_i && (mem_addr_i == ADDR_RX_DATA);
      st_tx_hit = mem_we_i && (mem_addr_i == ADDR_TX_DATA);
      rx_push   = uart_rx_data_out_valid && !rx_full;
      rx_pop    = ld_rx_hit && !rx_empty;
      tx_push   = st_tx_hit && !tx_full;
      tx_pop    = !tx_empty && uart_tx_data_in_ready;
   end

   uart_mmio_bridge_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rx_push),
      .wdata_i (uart_rx_data_out),
      .pop_i   (rx_pop),
      .head_o  (rx_head),
      .empty_o (rx_empty),
      .full_o  (rx_full)
   );

   uart_mmio_bridge_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tx_push),
      .wdata_i (mem_wdata_i[7:0]),
      .pop_i   (tx_pop),
      .head_o  (tx_head),
      .empty_o (tx_empty),
      .full_o  (tx_full)
   );

   // Overflow is sticky: set by a TX store that sees the pre-edge full flag, cleared only by reset.
   always_comb begin
      tx_overflow_d = tx_overflow_q;
      if (st_tx_hit && tx_full) tx_overflow_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_overflow_q <= 1'b0;
      else        tx_overflow_q <= tx_overflow_d;
   end

   // Status and data toward ex_wb and the UART; empty FIFOs present zero data.
   always_comb begin
      uart_rx_data_out_ready = !rx_full;
      uart_rx_out_valid      = !rx_empty;
      uart_read_o            = rx_empty ? 8'h00 : rx_head;
      uart_tx_in_ready       = !tx_full;
      uart_tx_data_in_valid  = !tx_empty;
      uart_tx_data_in        = tx_empty ? 8'h00 : tx_head;
      tx_overflow_o          = tx_overflow_q;
   end

endmodule
